// File: rtl/store_align_unit.sv
// MEM-stage store aligner: lane-positions store data, builds byte enables and issues one or two
// word-aligned bus beats. Define MISALIGNED_SPLIT_EN to split boundary-crossing stores.
module store_align_unit #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    output logic              st_done,
    output logic              st_err
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t            state, state_nxt;
    logic [OFF-1:0]    off;
    logic [3:0]        size;
    logic              illegal, misaligned, reject;
    logic [NB-1:0]     byte_en;
    logic [XLEN-1:0]   data_mask;
    logic [2*NB-1:0]   mask2;
    logic [2*XLEN-1:0] data2;
    logic [XLEN-1:0]   beat0_addr;
    logic [XLEN-1:0]   hi_addr, hi_data;
    logic [NB-1:0]     hi_be;
    logic              hs, final_hs, accept;

    assign off        = req_addr[OFF-1:0];
    assign size       = 4'd1 << req_funct3[1:0];
    assign illegal    = req_funct3[2] | (size > 4'(NB));
    assign misaligned = (4'(off) & (size - 4'd1)) != 4'd0;

`ifdef MISALIGNED_SPLIT_EN
    assign reject = illegal;
`else
    assign reject = illegal | misaligned;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        byte_en   = '0;
        data_mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(size)) begin
                byte_en[i]         = 1'b1;
                data_mask[8*i +: 8] = 8'hFF;
            end
        end
    end

    // Upper bytes are masked off before the shift so they cannot leak into the beat1 lanes.
    assign mask2      = {NB'(0), byte_en} << off;
    assign data2      = {XLEN'(0), req_wdata & data_mask} << {off, 3'b000};
    assign beat0_addr = {req_addr[XLEN-1:OFF], OFF'(0)};

    assign mem_valid = (state != IDLE);
    assign hs        = mem_valid & mem_ready;
    assign final_hs  = hs & ((state == BEAT1) | ((state == BEAT0) & (hi_be == '0)));
    assign req_ready = (state == IDLE) | final_hs;
    assign accept    = req_valid & req_ready;
    assign st_done   = final_hs;

    always_comb begin
        state_nxt = state;
        case (state)
            BEAT0:   if (hs) state_nxt = (hi_be != '0) ? BEAT1 : IDLE;
            BEAT1:   if (hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (accept && !reject) state_nxt = BEAT0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            st_err    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            hi_addr   <= '0;
            hi_data   <= '0;
            hi_be     <= '0;
        end else begin
            state  <= state_nxt;
            st_err <= accept & reject;
            if (accept && !reject) begin
                mem_addr  <= beat0_addr;
                mem_wdata <= data2[XLEN-1:0];
                mem_be    <= mask2[NB-1:0];
                hi_addr   <= beat0_addr + XLEN'(NB);
                hi_data   <= data2[2*XLEN-1:XLEN];
                hi_be     <= mask2[2*NB-1:NB];
            end else if (state == BEAT0 && hs && hi_be != '0) begin
                mem_addr  <= hi_addr;
                mem_wdata <= hi_data;
                mem_be    <= hi_be;
            end
        end
    end
endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: XLEN=32 instance for most steps, XLEN=64 instance for SD.
module tb_store_align_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, mem_valid, mem_ready, st_done, st_err;
    logic [31:0] req_addr, req_wdata, mem_addr, mem_wdata;
    logic [2:0]  req_funct3;
    logic [3:0]  mem_be;

    logic        v64, rdy64, mv64, mr64, done64, err64;
    logic [63:0] a64, d64, ma64, md64;
    logic [2:0]  f64;
    logic [7:0]  be64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_align_unit #(.XLEN(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .st_done(st_done), .st_err(st_err)
    );

    store_align_unit #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .req_valid(v64), .req_ready(rdy64),
        .req_addr(a64), .req_funct3(f64), .req_wdata(d64),
        .mem_valid(mv64), .mem_ready(mr64), .mem_addr(ma64),
        .mem_wdata(md64), .mem_be(be64), .st_done(done64), .st_err(err64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge; checks then run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        chk({tag, ".valid"}, 64'(mem_valid), 64'd1);
        chk({tag, ".addr"},  64'(mem_addr),  64'(a));
        chk({tag, ".be"},    64'(mem_be),    64'(be));
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'(d));
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        req(1'b0, 3'd0, 32'd0, 32'd0);
        v64 = 1'b0; f64 = 3'd0; a64 = '0; d64 = '0; mr64 = 1'b1;
        #3;
        chk("rst.valid", 64'(mem_valid), 64'd0);
        chk("rst.addr",  64'(mem_addr),  64'd0);
        chk("rst.wdata", 64'(mem_wdata), 64'd0);
        chk("rst.be",    64'(mem_be),    64'd0);
        chk("rst.err",   64'(st_err),    64'd0);
        chk("rst.ready", 64'(req_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // SW aligned, single beat, st_done in the beat cycle
        req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        #1 chk("sw.ready", 64'(req_ready), 64'd1);
        tick();
        req(1'b0, 3'd0, 32'd0, 32'd0);
        #1 beat("sw", 32'h100, 4'b1111, 32'hDEADBEEF);
        chk("sw.done", 64'(st_done), 64'd1);
        tick();
        #1 chk("sw.idle", 64'(mem_valid), 64'd0);

        // SB 0x103 then back-to-back SB 0x101 accepted on the final handshake
        req(1'b1, 3'b000, 32'h103, 32'hFFFFFFAB);
        tick();
        req(1'b1, 3'b000, 32'h101, 32'h000000CD);
        #1 beat("sb0", 32'h100, 4'b1000, 32'hAB000000);
        chk("sb0.done",  64'(st_done),   64'd1);
        chk("sb0.ready", 64'(req_ready), 64'd1);
        tick();
        req(1'b0, 3'd0, 32'd0, 32'd0);
        #1 beat("sb1", 32'h100, 4'b0010, 32'h0000CD00);
        tick();
        #1 chk("sb.idle", 64'(mem_valid), 64'd0);

        // SH 0x103 crosses the word boundary
        req(1'b1, 3'b001, 32'h103, 32'hABCD1234);
        tick();
        req(1'b0, 3'd0, 32'd0, 32'd0);
`ifdef MISALIGNED_SPLIT_EN
        #1 beat("shx0", 32'h100, 4'b1000, 32'h34000000);
        chk("shx0.done", 64'(st_done), 64'd0);
        tick();
        #1 beat("shx1", 32'h104, 4'b0001, 32'h00000012);
        chk("shx1.done", 64'(st_done), 64'd1);
        tick();
`else
        #1 chk("shx.valid", 64'(mem_valid), 64'd0);
        chk("shx.err", 64'(st_err), 64'd1);
        tick();
        #1 chk("shx.err_clr", 64'(st_err), 64'd0);
`endif
        #1 chk("shx.idle", 64'(mem_valid), 64'd0);

        // SH 0x101: misaligned but inside one word
        req(1'b1, 3'b001, 32'h101, 32'h00001234);
        tick();
        req(1'b0, 3'd0, 32'd0, 32'd0);
`ifdef MISALIGNED_SPLIT_EN
        #1 beat("shw", 32'h100, 4'b0110, 32'h00123400);
        chk("shw.done", 64'(st_done), 64'd1);
`else
        #1 chk("shw.valid", 64'(mem_valid), 64'd0);
        chk("shw.err", 64'(st_err), 64'd1);
`endif
        tick();

        // Stall: mem_ready low for 3 cycles in BEAT0
        mem_ready = 1'b0;
        req(1'b1, 3'b010, 32'h200, 32'h11223344);
        tick();
        req(1'b1, 3'b000, 32'h300, 32'h00000055);
        for (int i = 0; i < 3; i++) begin
            #1 beat("stall", 32'h200, 4'b1111, 32'h11223344);
            chk("stall.ready", 64'(req_ready), 64'd0);
            chk("stall.done",  64'(st_done),   64'd0);
            tick();
        end
        req(1'b0, 3'd0, 32'd0, 32'd0);
        mem_ready = 1'b1;
        #1 chk("stall.release_done", 64'(st_done), 64'd1);
        tick();
        #1 chk("stall.idle", 64'(mem_valid), 64'd0);

        // SW 0x102, reset asserted during BEAT1
        req(1'b1, 3'b010, 32'h102, 32'hA1B2C3D4);
        tick();
        req(1'b0, 3'd0, 32'd0, 32'd0);
`ifdef MISALIGNED_SPLIT_EN
        #1 beat("swx0", 32'h100, 4'b1100, 32'hC3D40000);
        tick();
        #1 beat("swx1", 32'h104, 4'b0011, 32'h0000A1B2);
`else
        #1 chk("swx.err", 64'(st_err), 64'd1);
`endif
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", 64'(mem_valid), 64'd0);
        chk("mrst.addr",  64'(mem_addr),  64'd0);
        chk("mrst.wdata", 64'(mem_wdata), 64'd0);
        chk("mrst.be",    64'(mem_be),    64'd0);
        chk("mrst.err",   64'(st_err),    64'd0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick();
        #1 chk("mrst.nobeat1", 64'(mem_valid), 64'd0);
        tick();
        #1 chk("mrst.nobeat2", 64'(mem_valid), 64'd0);

        // Illegal encodings at XLEN=32
        req(1'b1, 3'b011, 32'h108, 32'h12345678);
        #1 chk("sd32.ready", 64'(req_ready), 64'd1);
        tick();
        req(1'b0, 3'd0, 32'd0, 32'd0);
        #1 chk("sd32.valid", 64'(mem_valid), 64'd0);
        chk("sd32.err", 64'(st_err), 64'd1);
        req(1'b1, 3'b100, 32'h100, 32'h12345678);
        tick();
        req(1'b0, 3'd0, 32'd0, 32'd0);
        #1 chk("f3hi.valid", 64'(mem_valid), 64'd0);
        chk("f3hi.err", 64'(st_err), 64'd1);
        tick();
        #1 chk("f3hi.err_clr", 64'(st_err), 64'd0);

        // XLEN=64: SD 0x8 then SW 0x4 back to back
        v64 = 1'b1; f64 = 3'b011; a64 = 64'h8; d64 = 64'h0123456789ABCDEF;
        tick();
        v64 = 1'b1; f64 = 3'b010; a64 = 64'h4; d64 = 64'hFFFFFFFFCAFEF00D;
        #1 chk("sd64.valid", 64'(mv64), 64'd1);
        chk("sd64.addr",  ma64, 64'h8);
        chk("sd64.be",    64'(be64), 64'hFF);
        chk("sd64.wdata", md64, 64'h0123456789ABCDEF);
        chk("sd64.done",  64'(done64), 64'd1);
        tick();
        v64 = 1'b0;
        #1 chk("sw64.addr", ma64, 64'h0);
        chk("sw64.be",    64'(be64), 64'hF0);
        chk("sw64.wdata", md64, 64'hCAFEF00D00000000);
        chk("sw64.err",   64'(err64), 64'd0);
        tick();
        #1 chk("sw64.idle", 64'(mv64), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
